imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
//  Inverse of the immediate generator. Takes a 64-bit immediate, an immgen_op
//  format code and a base instruction word (opcode/rd/rs/funct fields, with the
//  immediate bits ignored). Scatters the immediate into the RISC-V bit
//  positions and returns the packed 32-bit instruction.
//  Used by the self-test instruction generator and by the boot-ROM patcher.
//  Two-stage valid/ready pipeline; optional representability checking.
// PARAMETERS
//  CNT_W  16  width of saturating encode-error counter err_cnt
// PORTS
//  clk        in   1      system clock, rising edge
//  rstn       in   1      asynchronous active-low reset
//  in_valid   in   1      request valid
//  in_ready   out  1      request accepted when in_valid&&in_ready
//  immgen_op  in   3      0 zero,1 I,2 S,3 B,4 U,5 J,6 CSR,7 reserved
//  imm        in   64     immediate value (two's complement)
//  base_inst  in   32     instruction with non-immediate fields filled
//  out_valid  out  1      result valid
//  out_ready  in   1      result consumed when out_valid&&out_ready
//  inst       out  32     packed instruction
//  out_err    out  1      imm not representable in the format (qualified by out_valid)
//  err_cnt    out  CNT_W  count of errored results delivered
// BEHAVIOUR
//  Reset (rstn=0, async): s1_valid=0, s2_valid=0, out_valid=0, inst=0,
//   out_err=0, err_cnt=0. Any in-flight request is discarded.
//  Pipeline: S1 registers request; S2 registers encoded inst/out_err.
//   Latency 2 cycles, accept to out_valid, with out_ready held 1.
//   Throughput 1/cycle.
//   s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv.
//   in_ready = s1_adv (combinational from out_ready; no comb path in->out).
//   Full (both stages valid, out_ready=0): in_ready=0, all state held.
//   Simultaneous pop+push at full: both occur the same cycle. No bubble, no loss.
//   Order strictly preserved. inst/out_err stable while out_valid&&!out_ready.
//  Packing: inst = base_inst, then the immediate bits below are overwritten:
//   zero: none.  I: [31:20]=imm[11:0].  S: [31:25]=imm[11:5], [11:7]=imm[4:0].
//   B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
//   U: [31:12]=imm[31:12].  J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11],
//   [19:12]=imm[19:12].  CSR: [19:15]=imm[4:0].  op 7: none, out_err=1 always.
//  Range rules (used only when checking is enabled):
//   I/S: imm[63:11] all equal.  B: imm[63:12] all equal and imm[0]=0.
//   U: imm[63:31] all equal and imm[11:0]=0.  J: imm[63:20] all equal and imm[0]=0.
//   CSR: imm[63:5]=0.  zero: imm==0.
//  err_cnt: +1 on each handshake of a result with out_err=1.
//   Saturates at all-ones; never wraps.
// CONFIGURATION
//  IMM_ENC_RANGE_CHECK_EN defined:
//   - Range rules are evaluated in S2 and drive out_err.
//   - err_cnt counts errored results.
//   - inst is still packed by truncation.
//  Not defined:
//   - out_err=1 only for op 7; otherwise 0.
//   - err_cnt tied to 0; range logic absent.
//   - Out-of-range immediates are silently truncated.
// TESTING
//  1. I: base=0x00000013, imm=0xFFFF_FFFF_FFFF_FFFF, op=1
//     -> inst=0xFFF00013, out_err=0, 2 cycles later.
//  2. B: base=0x00000063, imm=-4, op=3 -> inst=0xFE000EE3.
//     U: base=0x37, imm=0x12345000, op=4 -> 0x12345037.
//     J: base=0x6F, imm=0x800, op=5 -> 0x0010006F.
//  3. Range (macro on): op=1, imm=0x800, base=0x13
//     -> inst=0x80000013, out_err=1, err_cnt 0->1.
//     Macro off: same inst, out_err=0.
//  4. Backpressure: out_ready=0, offer 3 back-to-back requests
//     -> 2 accepted, in_ready=0 on the 3rd.
//     Then out_ready=1 -> all 3 delivered in order, 1 per cycle.
//  5. Reset mid-op: 2 requests in flight, pulse rstn=0 asynchronously
//     -> out_valid=0 immediately, err_cnt=0, nothing delivered after reset.
//  6. Saturation (CNT_W=2): 5 errored results -> err_cnt=3.

Source files
------------

// File: rtl/imm_encoder.sv
// Scatters a 64-bit immediate into a RISC-V instruction word; two-stage valid/ready pipeline, 2-cycle latency, stalls cleanly under out_ready=0.
// Define IMM_ENC_RANGE_CHECK_EN to flag and count immediates that do not fit the selected format.
module imm_encoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       immgen_op,
   input  logic [63:0]      imm,
   input  logic [31:0]      base_inst,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      inst,
   output logic             out_err,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [2:0] {
      OP_ZERO = 3'd0,
      OP_I    = 3'd1,
      OP_S    = 3'd2,
      OP_B    = 3'd3,
      OP_U    = 3'd4,
      OP_J    = 3'd5,
      OP_CSR  = 3'd6,
      OP_RSVD = 3'd7
   } op_e;

   logic        s1_valid_q;
   op_e         s1_op_q;
   logic [63:0] s1_imm_q;
   logic [31:0] s1_base_q;

   logic        s2_valid_q;
   logic [31:0] inst_q;
   logic        err_q;

   logic        s1_adv;
   logic        s2_adv;
   logic [31:0] inst_d;
   logic        err_d;
   logic        range_bad;

   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= OP_ZERO;
         s1_imm_q   <= '0;
         s1_base_q  <= '0;
      end else if (s1_adv) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_op_q   <= op_e'(immgen_op);
            s1_imm_q  <= imm;
            s1_base_q <= base_inst;
         end
      end
   end

   always_comb begin
      inst_d = s1_base_q;
      case (s1_op_q)
         OP_I:   inst_d[31:20] = s1_imm_q[11:0];
         OP_S: begin
            inst_d[31:25] = s1_imm_q[11:5];
            inst_d[11:7]  = s1_imm_q[4:0];
         end
         OP_B: begin
            inst_d[31]    = s1_imm_q[12];
            inst_d[30:25] = s1_imm_q[10:5];
            inst_d[11:8]  = s1_imm_q[4:1];
            inst_d[7]     = s1_imm_q[11];
         end
         OP_U:   inst_d[31:12] = s1_imm_q[31:12];
         OP_J: begin
            inst_d[31]    = s1_imm_q[20];
            inst_d[30:21] = s1_imm_q[10:1];
            inst_d[20]    = s1_imm_q[11];
            inst_d[19:12] = s1_imm_q[19:12];
         end
         OP_CSR: inst_d[19:15] = s1_imm_q[4:0];
         default: ;
      endcase
   end

`ifdef IMM_ENC_RANGE_CHECK_EN
   // v[63:lsb] all equal <=> the arithmetic shift leaves only sign copies
   function automatic logic fits(input logic [63:0] v, input int unsigned lsb);
      logic [63:0] t;
      t = $signed(v) >>> lsb;
      return (t == '0) || (t == '1);
   endfunction

   always_comb begin
      range_bad = 1'b0;
      case (s1_op_q)
         OP_ZERO:    range_bad = |s1_imm_q;
         OP_I, OP_S: range_bad = !fits(s1_imm_q, 11);
         OP_B:       range_bad = !fits(s1_imm_q, 12) || s1_imm_q[0];
         OP_U:       range_bad = !fits(s1_imm_q, 31) || (|s1_imm_q[11:0]);
         OP_J:       range_bad = !fits(s1_imm_q, 20) || s1_imm_q[0];
         OP_CSR:     range_bad = |s1_imm_q[63:5];
         default:    range_bad = 1'b0;
      endcase
   end
`else
   logic unused_imm_hi;
   assign unused_imm_hi = ^s1_imm_q[63:32];
   assign range_bad     = 1'b0;
`endif

   assign err_d = (s1_op_q == OP_RSVD) || range_bad;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s2_valid_q <= 1'b0;
         inst_q     <= '0;
         err_q      <= 1'b0;
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            inst_q <= inst_d;
            err_q  <= err_d;
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign inst      = inst_q;
   assign out_err   = err_q;

`ifdef IMM_ENC_RANGE_CHECK_EN
   logic [CNT_W-1:0] err_cnt_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_cnt_q <= '0;
      end else if (s2_valid_q && out_ready && err_q && (err_cnt_q != '1)) begin
         err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: packing per format, latency, backpressure,
// range flagging and counter saturation (tracks IMM_ENC_RANGE_CHECK_EN).
module tb_imm_encoder;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rstn;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       immgen_op;
   logic [63:0]      imm;
   logic [31:0]      base_inst;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      inst;
   logic             out_err;
   logic [CNT_W-1:0] err_cnt;

   int checks = 0;
   int errors = 0;
   logic [CNT_W-1:0] exp_cnt = '0;

`ifdef IMM_ENC_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   imm_encoder #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .immgen_op (immgen_op),
      .imm       (imm),
      .base_inst (base_inst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .inst      (inst),
      .out_err   (out_err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   // Expected counter follows the delivered error flag only when checking is built in
   task automatic note_result(input logic err);
      if (RC && err && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
   endtask

   // Drives one request with out_ready=1; returns the result and accept-to-valid latency (-1 on timeout)
   task automatic issue(input logic [2:0] op, input logic [63:0] im, input logic [31:0] base,
                        output logic [31:0] r_inst, output logic r_err, output int lat);
      @(negedge clk);
      in_valid = 1'b1; immgen_op = op; imm = im; base_inst = base; out_ready = 1'b1;
      r_inst = '0; r_err = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      if (out_valid) begin
         r_inst = inst;
         r_err  = out_err;
      end else begin
         lat = -1;
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", inst); end
      checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
      checks++; if (err_cnt !== '0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      rstn = 1'b1;
   endtask

   logic [2:0]  f_op   [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
   logic [63:0] f_imm  [7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h7FF, 64'hFFFF_FFFF_FFFF_FFFC,
                               64'h1234_5000, 64'h800, 64'h15, 64'h0};
   logic [31:0] f_base [7] = '{32'h0000_0013, 32'h0000_2023, 32'h0000_0063, 32'h0000_0037,
                               32'h0000_006F, 32'h0000_1073, 32'h1234_5678};
   logic [31:0] f_exp  [7] = '{32'hFFF0_0013, 32'h7E00_2FA3, 32'hFE00_0EE3, 32'h1234_5037,
                               32'h0010_006F, 32'h000A_9073, 32'h1234_5678};

   task automatic test_formats;
      logic [31:0] r_inst;
      logic        r_err;
      int          lat;
      for (int i = 0; i < 7; i++) begin
         issue(f_op[i], f_imm[i], f_base[i], r_inst, r_err, lat);
         note_result(r_err);
         checks++; if (lat !== 2) begin errors++; $display("FAIL fmt%0d_latency got=%0d exp=2", i, lat); end
         checks++; if (r_inst !== f_exp[i]) begin errors++; $display("FAIL fmt%0d_inst got=%h exp=%h", i, r_inst, f_exp[i]); end
         checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL fmt%0d_err got=%b exp=0", i, r_err); end
      end
      checks++; if (err_cnt !== '0) begin errors++; $display("FAIL fmt_err_cnt got=%0d exp=0", err_cnt); end
   endtask

   task automatic test_range;
      logic [31:0] r_inst;
      logic        r_err;
      int          lat;
      issue(3'd1, 64'h800, 32'h13, r_inst, r_err, lat);
      checks++; if (r_inst !== 32'h8000_0013) begin errors++; $display("FAIL range_i_inst got=%h exp=80000013", r_inst); end
      checks++; if (r_err !== RC) begin errors++; $display("FAIL range_i_err got=%b exp=%b", r_err, RC); end
      note_result(RC);
      checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL range_i_cnt got=%0d exp=%0d", err_cnt, exp_cnt); end
      issue(3'd4, 64'h1234_5001, 32'h37, r_inst, r_err, lat);
      checks++; if (r_inst !== 32'h1234_5037) begin errors++; $display("FAIL range_u_inst got=%h exp=12345037", r_inst); end
      checks++; if (r_err !== RC) begin errors++; $display("FAIL range_u_err got=%b exp=%b", r_err, RC); end
      note_result(RC);
      checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL range_u_cnt got=%0d exp=%0d", err_cnt, exp_cnt); end
   endtask

   task automatic test_reserved;
      logic [31:0] r_inst;
      logic        r_err;
      int          lat;
      issue(3'd7, 64'h0, 32'hDEAD_BEEF, r_inst, r_err, lat);
      checks++; if (r_inst !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rsvd_inst got=%h exp=deadbeef", r_inst); end
      checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL rsvd_err got=%b exp=1", r_err); end
      note_result(1'b1);
      checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL rsvd_cnt got=%0d exp=%0d", err_cnt, exp_cnt); end
   endtask

   task automatic test_backpressure;
      logic [31:0] exp_q [3] = '{32'h0010_0013, 32'h7BCD_E037, 32'h0020_006F};
      logic [31:0] got [$];
      int          at [$];
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; immgen_op = 3'd1; imm = 64'h1; base_inst = 32'h13;
      @(negedge clk);
      immgen_op = 3'd4; imm = 64'h7BCD_E000; base_inst = 32'h37;
      @(negedge clk);
      immgen_op = 3'd5; imm = 64'h2; base_inst = 32'h6F;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); end
      repeat (3) begin @(negedge clk); #1; end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b1 || inst !== exp_q[0]) begin
         errors++; $display("FAIL bp_hold_out got=%b/%h exp=1/%h", out_valid, inst, exp_q[0]); end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_pushpop_in_ready got=%b exp=1", in_ready); end
      for (int k = 0; k < 8; k++) begin
         if (out_valid) begin got.push_back(inst); at.push_back(k); end
         @(negedge clk);
         in_valid = 1'b0;
         #1;
      end
      checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_count got=%0d exp=3", got.size()); end
      for (int i = 0; i < 3; i++) begin
         if (i < got.size()) begin
            checks++; if (got[i] !== exp_q[i] || at[i] != i) begin
               errors++; $display("FAIL bp_order%0d got=%h@%0d exp=%h@%0d", i, got[i], at[i], exp_q[i], i); end
         end
      end
   endtask

   task automatic test_saturation;
      logic [31:0] r_inst;
      logic        r_err;
      int          lat;
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      exp_cnt = '0;
      for (int i = 0; i < 5; i++) begin
         issue(3'd7, 64'h0, 32'h13, r_inst, r_err, lat);
         note_result(r_err);
         checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL sat%0d_cnt got=%0d exp=%0d", i, err_cnt, exp_cnt); end
      end
      checks++; if (err_cnt !== (RC ? 2'd3 : 2'd0)) begin
         errors++; $display("FAIL sat_final got=%0d exp=%0d", err_cnt, RC ? 3 : 0); end
   endtask

   task automatic test_reset_mid;
      int seen = 0;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; immgen_op = 3'd7; imm = 64'h0; base_inst = 32'h13;
      @(negedge clk);
      immgen_op = 3'd1; imm = 64'h5;
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
      checks++; if (err_cnt !== '0) begin errors++; $display("FAIL rstmid_err_cnt got=%0d exp=0", err_cnt); end
      checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rstmid_inst got=%h exp=0", inst); end
      @(negedge clk);
      rstn = 1'b1;
      out_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_flush got=%0d deliveries exp=0", seen); end
   endtask

   initial begin
      rstn = 1'b0; in_valid = 1'b0; immgen_op = '0; imm = '0; base_inst = '0; out_ready = 1'b1;
      test_reset();
      test_formats();
      test_range();
      test_reserved();
      test_backpressure();
      test_saturation();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
